// File: rtl/packed_lane_serializer.sv
// Packed multi-lane word to lane-slice beat serializer with optional replication.
// Lane order per word is ascending or descending and is fixed when the word is accepted.
module packed_lane_serializer #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 2,
  parameter int unsigned TAGW  = 4,
  parameter int unsigned REPW  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [0:LANES-1][WIDTH-1:0]   in_data,
  input  logic [0:TAGW-1]               in_tag,
  input  logic                          in_desc,
  input  logic [REPW-1:0]               in_rep,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [0:SLICE-1][WIDTH-1:0]   out_data,
  output logic [0:TAGW-1]               out_tag,
  output logic                          out_first,
  output logic                          out_last
);

  localparam int unsigned BEATS = LANES / SLICE;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;

  if ((LANES % SLICE) != 0) begin : g_bad_slice
    $error("packed_lane_serializer: LANES must be a multiple of SLICE");
  end

  typedef logic [0:LANES-1][WIDTH-1:0] word_t;
  typedef logic [0:SLICE-1][WIDTH-1:0] slice_t;
  typedef enum logic [0:0] {StIdle, StSend} state_t;

  state_t          r_state;
  word_t           r_word;
  logic            r_desc;
  logic [REPW-1:0] r_rep_max;
  logic [BW-1:0]   r_beat;
  logic [REPW-1:0] r_rep;
  logic            r_out_valid;
  slice_t          r_out_data;
  logic [0:TAGW-1] r_out_tag;
  logic            r_first;
  logic            r_last;

  logic            w_hs;
  logic            w_accept;
  logic [REPW-1:0] w_rep_max;
  logic [BW-1:0]   w_beat_nxt;
  logic [REPW-1:0] w_rep_nxt;

  // Descending beats start from the top lane group; lanes inside a beat stay ascending.
  function automatic slice_t f_slice(input word_t w, input logic desc, input logic [BW-1:0] k);
    slice_t s;
    int     base;
    base = desc ? (int'(LANES) - int'(SLICE) - int'(k) * int'(SLICE))
                : (int'(k) * int'(SLICE));
    for (int j = 0; j < int'(SLICE); j++) begin
      s[j] = w[LW'(base + j)];
    end
    return s;
  endfunction

  assign w_hs      = r_out_valid & out_ready;
  assign in_ready  = (r_state == StIdle) | (w_hs & r_last);
  assign w_accept  = in_valid & in_ready;
  assign w_rep_max = (in_rep == '0) ? '0 : in_rep - 1'b1;

  always_comb begin
    w_beat_nxt = r_beat + 1'b1;
    w_rep_nxt  = r_rep;
    if (r_beat == BW'(BEATS - 1)) begin
      w_beat_nxt = '0;
      w_rep_nxt  = r_rep + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_word      <= '0;
      r_desc      <= 1'b0;
      r_rep_max   <= '0;
      r_beat      <= '0;
      r_rep       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
    end else if (w_accept) begin
      // Covers both the idle accept and the zero-bubble accept on the last handshake.
      r_state     <= StSend;
      r_word      <= in_data;
      r_desc      <= in_desc;
      r_rep_max   <= w_rep_max;
      r_beat      <= '0;
      r_rep       <= '0;
      r_out_valid <= 1'b1;
      r_out_data  <= f_slice(in_data, in_desc, '0);
      r_out_tag   <= in_tag;
      r_first     <= 1'b1;
      r_last      <= (w_rep_max == '0) && (BEATS == 1);
    end else if (w_hs) begin
      if (r_last) begin
        r_state     <= StIdle;
        r_out_valid <= 1'b0;
        r_first     <= 1'b0;
        r_last      <= 1'b0;
      end else begin
        r_beat     <= w_beat_nxt;
        r_rep      <= w_rep_nxt;
        r_out_data <= f_slice(r_word, r_desc, w_beat_nxt);
        r_first    <= 1'b0;
        r_last     <= (w_rep_nxt == r_rep_max) && (w_beat_nxt == BW'(BEATS - 1));
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign out_first = r_first;
  assign out_last  = r_last;

endmodule

// File: tb/tb_packed_lane_serializer.sv
// Directed bench for packed_lane_serializer (LANES=4, WIDTH=8, SLICE=2, REPW=3).
module tb_packed_lane_serializer;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [0:3][7:0]  in_data;
  logic [0:3]       in_tag;
  logic             in_desc;
  logic [2:0]       in_rep;
  logic             out_valid;
  logic             out_ready;
  logic [0:1][7:0]  out_data;
  logic [0:3]       out_tag;
  logic             out_first;
  logic             out_last;

  int n_chk  = 0;
  int n_pass = 0;

  packed_lane_serializer #(
    .LANES(4), .WIDTH(8), .SLICE(2), .TAGW(4), .REPW(3)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .in_desc   (in_desc),
    .in_rep    (in_rep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [15:0] d, input logic f, input logic l,
                      input logic [3:0] t);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".first"}, 32'(out_first), 32'(f));
    chk({tag, ".last"},  32'(out_last),  32'(l));
    chk({tag, ".tag"},   32'(out_tag),   32'(t));
  endtask

  // Offers a word this cycle, checks it is taken, and advances to its first beat.
  task automatic offer(input string tag, input logic [31:0] d, input logic [3:0] t,
                       input logic desc, input logic [2:0] rep);
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    in_desc  = desc;
    in_rep   = rep;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    in_desc   = 1'b0;
    in_rep    = '0;
    out_ready = 1'b1;
    #3;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data",  32'(out_data),  32'd0);
    chk("rst.tag",   32'(out_tag),   32'd0);
    chk("rst.first", 32'(out_first), 32'd0);
    chk("rst.last",  32'(out_last),  32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // 1: ascending, rep=1
    offer("t1", 32'h11223344, 4'h1, 1'b0, 3'd1);
    beat("t1.b0", 16'h1122, 1'b1, 1'b0, 4'h1);
    chk("t1.b0.in_ready", 32'(in_ready), 32'd0);
    step();
    beat("t1.b1", 16'h3344, 1'b0, 1'b1, 4'h1);
    chk("t1.b1.in_ready", 32'(in_ready), 32'd1);
    step();
    chk("t1.idle", 32'(out_valid), 32'd0);

    // 2: descending
    offer("t2", 32'h11223344, 4'h2, 1'b1, 3'd1);
    beat("t2.b0", 16'h3344, 1'b1, 1'b0, 4'h2);
    step();
    beat("t2.b1", 16'h1122, 1'b0, 1'b1, 4'h2);
    step();
    chk("t2.idle", 32'(out_valid), 32'd0);

    // 3: rep=3 gives six beats, then rep=0 behaves as rep=1
    offer("t3", 32'h11223344, 4'h3, 1'b0, 3'd3);
    for (int i = 0; i < 6; i++) begin
      beat($sformatf("t3.b%0d", i), (i % 2 == 1) ? 16'h3344 : 16'h1122,
           i == 0, i == 5, 4'h3);
      step();
    end
    chk("t3.idle", 32'(out_valid), 32'd0);
    offer("t3z", 32'h11223344, 4'h4, 1'b0, 3'd0);
    beat("t3z.b0", 16'h1122, 1'b1, 1'b0, 4'h4);
    step();
    beat("t3z.b1", 16'h3344, 1'b0, 1'b1, 4'h4);
    step();
    chk("t3z.idle", 32'(out_valid), 32'd0);

    // 4: stall on beat 0; input changes after accept must not leak in
    out_ready = 1'b0;
    offer("t4", 32'h11223344, 4'h6, 1'b0, 3'd1);
    in_data = 32'hDEADBEEF;
    in_desc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("t4.hold%0d", i), 16'h1122, 1'b1, 1'b0, 4'h6);
      chk($sformatf("t4.hold%0d.in_ready", i), 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    beat("t4.b0", 16'h1122, 1'b1, 1'b0, 4'h6);
    step();
    beat("t4.b1", 16'h3344, 1'b0, 1'b1, 4'h6);
    step();
    chk("t4.idle", 32'(out_valid), 32'd0);

    // 5: word B offered during A's last-beat handshake -> no bubble
    offer("t5a", 32'h11223344, 4'h3, 1'b0, 3'd1);
    step();
    beat("t5a.b1", 16'h3344, 1'b0, 1'b1, 4'h3);
    offer("t5b", 32'hAABBCCDD, 4'h5, 1'b0, 3'd1);
    beat("t5b.b0", 16'hAABB, 1'b1, 1'b0, 4'h5);
    step();
    beat("t5b.b1", 16'hCCDD, 1'b0, 1'b1, 4'h5);
    step();
    chk("t5.idle", 32'(out_valid), 32'd0);

    // 6: reset mid-word discards the remaining beat
    out_ready = 1'b0;
    offer("t6", 32'h11223344, 4'h7, 1'b0, 3'd1);
    beat("t6.b0", 16'h1122, 1'b1, 1'b0, 4'h7);
    rst_n = 1'b0;
    #2;
    chk("t6.rst.valid", 32'(out_valid), 32'd0);
    chk("t6.rst.last",  32'(out_last),  32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6.post%0d.valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("t6.post%0d.in_ready", i), 32'(in_ready), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
